psx_multi_pad_engine: RTL and testbench
=======================================

Name: psx_multi_pad_engine

Overview:
- Parametrised successor to the fixed four-port PSX controller emulator: services NUM_PORTS Parallel Playstation Bus (PPB) ports.
- Uses round-robin arbitration and generates real digital/analog pad replies (ID, 0x5A, button/axis bytes) from a host-written per-port state RAM.
- Sits between the host write path and the PPB interface; the PPB handshake is exposed as ports so the block can be verified standalone.

Parameters:
- NUM_PORTS, 4, number of emulated pads.
- PORT_BITS, 2, log2(NUM_PORTS).
- SLOT_BITS, 3, log2 of bytes of state RAM per port (8).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- write_addr  in  PORT_BITS+SLOT_BITS  host state RAM address {port, slot}.
- write_data  in  8  host write data.
- write_en  in  1  host write strobe.
- ppb_irq_flags  in  NUM_PORTS  per-port "command byte ready".
- ppb_port  out  PORT_BITS  port selected for the PPB operation.
- ppb_read  out  1  request command byte read.
- ppb_write  out  1  request reply byte write.
- ppb_ack  out  1  one-cycle strobe: acknowledge the current byte.
- ppb_reply  out  8  reply byte.
- ppb_done  in  1  PPB operation complete (one cycle).
- ppb_command  in  8  received command byte, valid with ppb_done.
- ppb_index  in  5  byte index of the command within the transaction.

Behaviour:
- State RAM: sync_dualport_sram, 8-bit data, 1-cycle read latency. Host port is write-only.
- Slot 0 = pad ID byte (e.g. 0x41 digital, 0x73 analog). Slots 1..7 = data bytes.
- Data length L = 2 * ID[3:0], clamped to 7.
- Reset: all outputs 0; state S_IDLE; rr_last = NUM_PORTS-1, so port 0 has priority first.
- S_IDLE: if ppb_irq_flags != 0, pick the first set flag searching from rr_last+1 with modulo-NUM_PORTS wrap. Drive ppb_port, assert ppb_read, update rr_last, go to S_READ_CMD. Otherwise ppb_read=0. ppb_ack and ppb_write are forced to 0.
- S_READ_CMD: wait for ppb_done, then capture cmd/index and drop ppb_read. Decide the reply for index i:
  - i=0, cmd!=0x01 -> no reply (foreign device, e.g. memcard 0x81); go to S_IDLE.
  - i=0, cmd==0x01 -> reply = RAM[port][0] (ID).
  - i=1 -> reply 0x5A. Any cmd value is accepted; cmd 0x42 is not required.
  - 2 <= i < 2+L -> reply = RAM[port][i-1].
  - i >= 2+L -> no reply; go to S_IDLE. ppb_ack is not asserted, which ends the transaction.
  - RAM cases go to S_FETCH, which drives the read address. Constant cases go directly to S_WRITE.
- S_FETCH: one wait cycle for RAM latency; then go to S_WRITE. ID-derived length for index >= 2 comes from a per-port latched ID, captured when index-0 is served.
- S_WRITE entry cycle: ppb_reply valid, ppb_write=1, ppb_ack=1 for exactly one cycle. Hold ppb_write until ppb_done, then ppb_write=0 and go to S_IDLE.
- Latency: ppb_done (read) to ppb_write is 1 cycle for constant replies and 2 cycles for RAM replies.
- Simultaneous host write to the slot being fetched: the read returns the old data (RAM read-before-write). No stall.
- ppb_irq_flags changing mid-operation is ignored until S_IDLE.
- Reset mid-operation aborts immediately to reset values; latched IDs are cleared to 0 (L=0).
- ppb_index > 2+7 is never given data; the no-reply rule covers it.
- Starvation bound: any raised flag is served within NUM_PORTS operations.

Decomposition:
- Shared package/constants: PSX_CMD_START=8'h01, PSX_CMD_POLL=8'h42, PSX_PAD_MAGIC=8'h5A, PSX_ID_DIGITAL=8'h41, PSX_ID_ANALOG=8'h73, SLOT_ID=0, state encodings S_IDLE/S_READ_CMD/S_FETCH/S_WRITE.
- Sub-module psx_rr_arbiter (NUM_PORTS, PORT_BITS): inputs are request vector, last, enable; outputs are grant index and valid. It is purely combinational plus the rr_last register.
- RAM is the existing sync_dualport_sram.

Test Plan:
- Reset, then write RAM port0 {0x41, 0xFE, 0xFF}; emulate poll 0x01,0x42,0x00,0x00,0x00 on port 0 -> replies 0x41, 0x5A, 0xFE, 0xFF; ack on 4 bytes; the 5th command gets no ack and no write.
- Port2 ID 0x73 with slots 1..6 = 0x11..0x66 -> 8 replies: 0x73, 0x5A, 0x11..0x66; no ack on index 8.
- Index-0 command 0x81 on port1 -> ppb_write and ppb_ack stay 0; back to S_IDLE within 1 cycle.
- All flags held high continuously -> grant order 0,1,2,3,0,1…; after reset the first grant is port 0.
- Host write to port3 slot1 in the same cycle as S_FETCH reads it -> old value replied; the next poll returns the new value.
- Assert reset during S_WRITE -> all outputs 0 next edge; the following transaction starts fresh at S_IDLE with port-0 priority.

Source files
------------

// File: rtl/psx_multi_pad_engine_pkg.sv
// psx_multi_pad_engine_pkg
// Shared constants, FSM state encoding and helpers for the multi-pad PSX
// controller emulator.
//   - PSX protocol byte constants (start command, poll command, magic byte,
//     typical pad IDs)
//   - SLOT_ID: state RAM slot holding the pad ID byte
//   - state_e: engine FSM states
//   - padDataLen(): number of data bytes a pad returns, derived from its ID
package psx_multi_pad_engine_pkg;

  localparam logic [7:0] PSX_CMD_START  = 8'h01;
  localparam logic [7:0] PSX_CMD_POLL   = 8'h42;
  localparam logic [7:0] PSX_PAD_MAGIC  = 8'h5A;
  localparam logic [7:0] PSX_ID_DIGITAL = 8'h41;
  localparam logic [7:0] PSX_ID_ANALOG  = 8'h73;

  localparam int SLOT_ID      = 0;
  localparam int MAX_DATA_LEN = 7;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_READ_CMD = 2'd1,
    S_FETCH    = 2'd2,
    S_WRITE    = 2'd3
  } state_e;

  // The low ID nibble counts half-words of pad data; only 7 data slots exist
  // per port, so longer pads are truncated.
  function automatic logic [2:0] padDataLen(input logic [3:0] idLow);
    logic [4:0] raw;
    raw = {idLow, 1'b0};
    if (raw > 5'(MAX_DATA_LEN)) begin
      return 3'(MAX_DATA_LEN);
    end
    return raw[2:0];
  endfunction

endpackage

// File: rtl/psx_rr_arbiter.sv
// psx_rr_arbiter
// Round-robin selector over the per-port "command byte ready" flags. The
// search starts one past the most recently granted port and wraps, so every
// raised request is granted within NUM_PORTS grants.
// Ports:
//   clk, reset   clock and asynchronous active-high reset
//   req_i        request vector, one bit per port
//   enable_i     a grant taken this cycle advances the priority pointer
//   grant_o      index of the selected port (valid when valid_o)
//   valid_o      at least one request is present
module psx_rr_arbiter
  import psx_multi_pad_engine_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int PORT_BITS = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic                 enable_i,
  output logic [PORT_BITS-1:0] grant_o,
  output logic                 valid_o
);

  logic [PORT_BITS-1:0] last_q, last_d;

  // Candidate index wraps naturally at PORT_BITS, which matches the port
  // count because NUM_PORTS is a power of two.
  always_comb begin
    logic [PORT_BITS-1:0] cand;
    grant_o = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      cand = last_q + PORT_BITS'(k);
      if (!valid_o && req_i[cand]) begin
        valid_o = 1'b1;
        grant_o = cand;
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (enable_i && valid_o) begin
      last_d = grant_o;
    end
  end

  // Resetting to the highest port makes port 0 the first candidate.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= PORT_BITS'(NUM_PORTS - 1);
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/sync_dualport_sram.sv
// sync_dualport_sram
// Simple dual-port synchronous RAM: one write port, one read port, one-cycle
// read latency. A read and a write to the same address on the same edge
// returns the old contents (read-before-write).
// Ports:
//   clk              clock
//   we_i/waddr_i/wdata_i   write strobe, address, data
//   re_i/raddr_i     read enable and address
//   rdata_o          registered read data, holds while re_i is low
module sync_dualport_sram #(
  parameter int ADDR_BITS = 5,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [ADDR_BITS-1:0] waddr_i,
  input  logic [DATA_BITS-1:0] wdata_i,
  input  logic                 re_i,
  input  logic [ADDR_BITS-1:0] raddr_i,
  output logic [DATA_BITS-1:0] rdata_o
);

  logic [DATA_BITS-1:0] mem [2**ADDR_BITS];

  // Both accesses use non-blocking updates, so a same-edge read sees the
  // value from before the write.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_o <= mem[raddr_i];
    end
  end

endmodule

// File: rtl/psx_multi_pad_engine.sv
// psx_multi_pad_engine
// Emulates NUM_PORTS PlayStation pads on a Parallel Playstation Bus. Picks a
// port with a pending command byte (round robin), reads the byte, and answers
// with the pad ID, the 0x5A magic byte or button/axis bytes taken from a
// host-written per-port state RAM.
// Ports:
//   clk, reset        clock and asynchronous active-high reset
//   write_addr_i      host state RAM address {port, slot}
//   write_data_i      host write data
//   write_en_i        host write strobe
//   ppb_irq_flags_i   per-port "command byte ready"
//   ppb_port_o        port selected for the current PPB operation
//   ppb_read_o        request a command byte read
//   ppb_write_o       request a reply byte write
//   ppb_ack_o         one-cycle acknowledge of the current byte
//   ppb_reply_o       reply byte, valid while ppb_write_o is high
//   ppb_done_i        PPB operation complete (one cycle)
//   ppb_command_i     received command byte, valid with ppb_done_i
//   ppb_index_i       byte index of that command within the transaction
module psx_multi_pad_engine
  import psx_multi_pad_engine_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int PORT_BITS = 2,
  parameter int SLOT_BITS = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [PORT_BITS+SLOT_BITS-1:0] write_addr_i,
  input  logic [7:0]                     write_data_i,
  input  logic                           write_en_i,
  input  logic [NUM_PORTS-1:0]           ppb_irq_flags_i,
  output logic [PORT_BITS-1:0]           ppb_port_o,
  output logic                           ppb_read_o,
  output logic                           ppb_write_o,
  output logic                           ppb_ack_o,
  output logic [7:0]                     ppb_reply_o,
  input  logic                           ppb_done_i,
  input  logic [7:0]                     ppb_command_i,
  input  logic [4:0]                     ppb_index_i
);

  localparam int ADDR_BITS = PORT_BITS + SLOT_BITS;

  state_e               state_q, state_d;
  logic [PORT_BITS-1:0] port_q, port_d;
  logic                 read_q, read_d;
  logic                 write_q, write_d;
  logic                 ack_q, ack_d;
  logic                 useRam_q, useRam_d;
  logic                 latchId_q, latchId_d;
  logic [7:0]           replyConst_q, replyConst_d;
  logic [SLOT_BITS-1:0] slot_q, slot_d;

  // Only the low ID nibble matters for the data length, so that is all that
  // is kept per port.
  logic [3:0]           padIdLow_q [NUM_PORTS];

  logic [PORT_BITS-1:0] grant;
  logic                 grantValid;
  logic                 ramRe;
  logic [ADDR_BITS-1:0] ramRaddr;
  logic [7:0]           ramRdata;
  logic [2:0]           dataLen;
  logic [4:0]           replyEnd;

  psx_rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .PORT_BITS (PORT_BITS)
  ) uArbiter (
    .clk      (clk),
    .reset    (reset),
    .req_i    (ppb_irq_flags_i),
    .enable_i (state_q == S_IDLE),
    .grant_o  (grant),
    .valid_o  (grantValid)
  );

  sync_dualport_sram #(
    .ADDR_BITS (ADDR_BITS),
    .DATA_BITS (8)
  ) uStateRam (
    .clk     (clk),
    .we_i    (write_en_i),
    .waddr_i (write_addr_i),
    .wdata_i (write_data_i),
    .re_i    (ramRe),
    .raddr_i (ramRaddr),
    .rdata_o (ramRdata)
  );

  // The read is issued only in S_FETCH so ramRdata stays stable for the
  // whole S_WRITE phase.
  assign ramRe    = (state_q == S_FETCH);
  assign ramRaddr = {port_q, slot_q};

  // Indices 2 .. replyEnd-1 carry data bytes; anything at or past replyEnd
  // is left unanswered, which ends the transaction.
  assign dataLen  = padDataLen(padIdLow_q[port_q]);
  assign replyEnd = 5'd2 + {2'b00, dataLen};

  always_comb begin
    state_d      = state_q;
    port_d       = port_q;
    read_d       = read_q;
    write_d      = write_q;
    ack_d        = 1'b0;
    useRam_d     = useRam_q;
    latchId_d    = latchId_q;
    replyConst_d = replyConst_q;
    slot_d       = slot_q;

    case (state_q)
      S_IDLE: begin
        write_d = 1'b0;
        if (grantValid) begin
          port_d  = grant;
          read_d  = 1'b1;
          state_d = S_READ_CMD;
        end else begin
          read_d = 1'b0;
        end
      end

      S_READ_CMD: begin
        if (ppb_done_i) begin
          read_d    = 1'b0;
          useRam_d  = 1'b0;
          latchId_d = 1'b0;
          state_d   = S_IDLE;
          if (ppb_index_i == 5'd0) begin
            // Anything but the start byte is addressed to another device
            // (e.g. a memory card), so stay silent.
            if (ppb_command_i == PSX_CMD_START) begin
              slot_d    = SLOT_BITS'(SLOT_ID);
              useRam_d  = 1'b1;
              latchId_d = 1'b1;
              state_d   = S_FETCH;
            end
          end else if (ppb_index_i == 5'd1) begin
            replyConst_d = PSX_PAD_MAGIC;
            write_d      = 1'b1;
            ack_d        = 1'b1;
            state_d      = S_WRITE;
          end else if (ppb_index_i < replyEnd) begin
            slot_d   = SLOT_BITS'(ppb_index_i - 5'd1);
            useRam_d = 1'b1;
            state_d  = S_FETCH;
          end
        end
      end

      S_FETCH: begin
        write_d = 1'b1;
        ack_d   = 1'b1;
        state_d = S_WRITE;
      end

      S_WRITE: begin
        if (ppb_done_i) begin
          write_d = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      port_q       <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      ack_q        <= 1'b0;
      useRam_q     <= 1'b0;
      latchId_q    <= 1'b0;
      replyConst_q <= '0;
      slot_q       <= '0;
    end else begin
      state_q      <= state_d;
      port_q       <= port_d;
      read_q       <= read_d;
      write_q      <= write_d;
      ack_q        <= ack_d;
      useRam_q     <= useRam_d;
      latchId_q    <= latchId_d;
      replyConst_q <= replyConst_d;
      slot_q       <= slot_d;
    end
  end

  // The ID byte is first visible on ramRdata in the S_WRITE entry cycle of
  // an index-0 reply; that is where it is captured for later length checks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        padIdLow_q[p] <= '0;
      end
    end else if (state_q == S_WRITE && ack_q && latchId_q) begin
      padIdLow_q[port_q] <= ramRdata[3:0];
    end
  end

  assign ppb_port_o  = port_q;
  assign ppb_read_o  = read_q;
  assign ppb_write_o = write_q;
  assign ppb_ack_o   = ack_q;
  assign ppb_reply_o = write_q ? (useRam_q ? ramRdata : replyConst_q) : 8'h00;

endmodule

// File: tb/tb_psx_multi_pad_engine.sv
// tb_psx_multi_pad_engine
// Self-checking bench for psx_multi_pad_engine. The bench plays the PPB side
// and the host, keeps a shadow of the pad state RAM, the latched pad IDs and
// the round-robin pointer, and predicts per operation which port is served and
// which reply byte (if any) must appear.
module tb_psx_multi_pad_engine;

  localparam int NUM_PORTS = 4;
  localparam int PORT_BITS = 2;
  localparam int SLOT_BITS = 3;
  localparam int SLOTS     = 8;

  logic       clk;
  logic       reset;
  logic [4:0] write_addr;
  logic [7:0] write_data;
  logic       write_en;
  logic [3:0] ppb_irq_flags;
  logic [1:0] ppb_port;
  logic       ppb_read;
  logic       ppb_write;
  logic       ppb_ack;
  logic [7:0] ppb_reply;
  logic       ppb_done;
  logic [7:0] ppb_command;
  logic [4:0] ppb_index;

  int assertCount = 0;
  int failCount   = 0;

  logic [7:0] shadowRam [NUM_PORTS][SLOTS];
  logic [7:0] modelId   [NUM_PORTS];
  int         modelLast;
  logic [1:0] expPort;
  logic [7:0] expReply;

  psx_multi_pad_engine #(
    .NUM_PORTS (NUM_PORTS),
    .PORT_BITS (PORT_BITS),
    .SLOT_BITS (SLOT_BITS)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .write_addr_i    (write_addr),
    .write_data_i    (write_data),
    .write_en_i      (write_en),
    .ppb_irq_flags_i (ppb_irq_flags),
    .ppb_port_o      (ppb_port),
    .ppb_read_o      (ppb_read),
    .ppb_write_o     (ppb_write),
    .ppb_ack_o       (ppb_ack),
    .ppb_reply_o     (ppb_reply),
    .ppb_done_i      (ppb_done),
    .ppb_command_i   (ppb_command),
    .ppb_index_i     (ppb_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at time %0t", name, actual, expected, $time);
    end
  endtask

  // Reply rules: index 0 answers only the start byte with the ID, index 1 is
  // always the magic byte, then 2*ID[3:0] (at most 7) data bytes follow.
  function automatic void predict(input int port, input logic [7:0] cmd, input int idx,
                                  output bit hasReply, output bit isRam,
                                  output logic [7:0] val, output int slot);
    int len;
    hasReply = 1'b0;
    isRam    = 1'b0;
    val      = 8'h00;
    slot     = 0;
    len      = 2 * int'(modelId[port][3:0]);
    if (len > 7) len = 7;
    if (idx == 0) begin
      if (cmd == 8'h01) begin
        hasReply = 1'b1;
        isRam    = 1'b1;
        slot     = 0;
        val      = shadowRam[port][0];
      end
    end else if (idx == 1) begin
      hasReply = 1'b1;
      val      = 8'h5A;
    end else if (idx < 2 + len) begin
      hasReply = 1'b1;
      isRam    = 1'b1;
      slot     = idx - 1;
      val      = shadowRam[port][slot];
    end
  endfunction

  task automatic hostWrite(input int port, input int slot, input logic [7:0] data);
    write_addr = 5'((port << 3) | slot);
    write_data = data;
    write_en   = 1'b1;
    @(negedge clk);
    write_en   = 1'b0;
    shadowRam[port][slot] = data;
  endtask

  task automatic modelReset();
    modelLast = NUM_PORTS - 1;
    for (int p = 0; p < NUM_PORTS; p++) modelId[p] = 8'h00;
  endtask

  // One full PPB operation: raise flags, read a command byte, then expect
  // either silence or a reply byte with a one-cycle ack.
  // litReply: -1 no literal, -2 literal "no reply", else the literal byte.
  task automatic applyStimulus(input int flags, input logic [7:0] cmd, input int idx,
                               input int litPort, input int litReply,
                               input bit collide, input logic [7:0] collideData,
                               input bit resetInWrite);
    int         port;
    int         slot;
    int         waitCnt;
    bit         hasReply;
    bit         isRam;
    logic [7:0] val;

    port = -1;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      int p;
      p = (modelLast + k) % NUM_PORTS;
      if (port < 0 && ((flags >> p) & 1) != 0) port = p;
    end
    modelLast = port;
    predict(port, cmd, idx, hasReply, isRam, val, slot);
    expPort  = 2'(port);
    expReply = val;
    if (litReply == -2) checkOutput("modelPinNoReply", 32'(hasReply), 0);
    if (litReply >= 0)  checkOutput("modelPinReply", 32'(val), 32'(litReply));

    ppb_irq_flags = 4'(flags);
    @(negedge clk);
    checkOutput("readAfterIrq", 32'(ppb_read), 1);
    checkOutput("portOnRead", 32'(ppb_port), 32'(port));
    if (litPort >= 0) checkOutput("portLiteral", 32'(ppb_port), 32'(litPort));
    ppb_irq_flags = (flags == 15) ? 4'hF : 4'($urandom);

    waitCnt = $urandom_range(0, 3);
    repeat (waitCnt) begin
      @(negedge clk);
      checkOutput("readHeld", 32'(ppb_read), 1);
    end

    ppb_done    = 1'b1;
    ppb_command = cmd;
    ppb_index   = 5'(idx);
    @(negedge clk);
    ppb_done    = 1'b0;
    ppb_command = 8'($urandom);
    ppb_index   = 5'($urandom);
    checkOutput("readDropped", 32'(ppb_read), 0);

    if (!hasReply) begin
      checkOutput("noWrite", 32'(ppb_write), 0);
      checkOutput("noAck", 32'(ppb_ack), 0);
    end else begin
      if (isRam) begin
        checkOutput("fetchNoWrite", 32'(ppb_write), 0);
        checkOutput("fetchNoAck", 32'(ppb_ack), 0);
        if (collide) begin
          write_addr = 5'((port << 3) | slot);
          write_data = collideData;
          write_en   = 1'b1;
        end
        @(negedge clk);
        write_en = 1'b0;
        if (collide) shadowRam[port][slot] = collideData;
      end
      checkOutput("writeEntry", 32'(ppb_write), 1);
      checkOutput("ackEntry", 32'(ppb_ack), 1);
      checkOutput("replyValue", 32'(ppb_reply), 32'(val));
      if (litReply >= 0) checkOutput("replyLiteral", 32'(ppb_reply), 32'(litReply));
      if (idx == 0) modelId[port] = val;

      if (resetInWrite) begin
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rstRead", 32'(ppb_read), 0);
        checkOutput("rstWrite", 32'(ppb_write), 0);
        checkOutput("rstAck", 32'(ppb_ack), 0);
        checkOutput("rstReply", 32'(ppb_reply), 0);
        checkOutput("rstPort", 32'(ppb_port), 0);
        ppb_irq_flags = 4'h0;
        reset = 1'b0;
        modelReset();
        return;
      end

      waitCnt = $urandom_range(0, 2);
      repeat (waitCnt) begin
        @(negedge clk);
        checkOutput("ackOneCycle", 32'(ppb_ack), 0);
        checkOutput("writeHeld", 32'(ppb_write), 1);
      end
      ppb_done = 1'b1;
      @(negedge clk);
      ppb_done = 1'b0;
      checkOutput("writeDropped", 32'(ppb_write), 0);
      checkOutput("ackAfterDone", 32'(ppb_ack), 0);
    end
    ppb_irq_flags = 4'h0;
  endtask

  // Per-cycle checks of whatever the DUT is currently driving on the bus.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        checkOutput("readWriteExclusive", 32'(ppb_read && ppb_write), 0);
        if (ppb_read || ppb_write) checkOutput("busPort", 32'(ppb_port), 32'(expPort));
        if (ppb_write) checkOutput("busReply", 32'(ppb_reply), 32'(expReply));
        if (ppb_ack) checkOutput("ackImpliesWrite", 32'(ppb_write), 1);
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    failCount++;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] port2Bytes [8];
    int         arbOrder [8];

    reset         = 1'b1;
    write_en      = 1'b0;
    write_addr    = '0;
    write_data    = '0;
    ppb_irq_flags = 4'h0;
    ppb_done      = 1'b0;
    ppb_command   = '0;
    ppb_index     = '0;
    expPort       = '0;
    expReply      = '0;
    modelReset();

    repeat (3) @(negedge clk);
    checkOutput("resetRead", 32'(ppb_read), 0);
    checkOutput("resetWrite", 32'(ppb_write), 0);
    checkOutput("resetAck", 32'(ppb_ack), 0);
    checkOutput("resetReply", 32'(ppb_reply), 0);
    checkOutput("resetPort", 32'(ppb_port), 0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("idleNoRead", 32'(ppb_read), 0);

    for (int p = 0; p < NUM_PORTS; p++)
      for (int s = 0; s < SLOTS; s++)
        hostWrite(p, s, 8'($urandom));

    $display("[TB] digital pad poll on port 0");
    hostWrite(0, 0, 8'h41);
    hostWrite(0, 1, 8'hFE);
    hostWrite(0, 2, 8'hFF);
    applyStimulus(1, 8'h01, 0, 0, 8'h41, 0, 0, 0);
    applyStimulus(1, 8'h42, 1, 0, 8'h5A, 0, 0, 0);
    applyStimulus(1, 8'h00, 2, 0, 8'hFE, 0, 0, 0);
    applyStimulus(1, 8'h00, 3, 0, 8'hFF, 0, 0, 0);
    applyStimulus(1, 8'h00, 4, 0, -2, 0, 0, 0);

    $display("[TB] analog pad poll on port 2");
    port2Bytes = '{8'h73, 8'h5A, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    hostWrite(2, 0, 8'h73);
    for (int s = 1; s <= 6; s++) hostWrite(2, s, 8'(s * 8'h11));
    for (int i = 0; i < 8; i++)
      applyStimulus(4, (i == 0) ? 8'h01 : 8'h42, i, 2, int'(port2Bytes[i]), 0, 0, 0);
    applyStimulus(4, 8'h00, 8, 2, -2, 0, 0, 0);

    $display("[TB] memory card command on port 1");
    applyStimulus(2, 8'h81, 0, 1, -2, 0, 0, 0);

    $display("[TB] host write colliding with fetch on port 3");
    hostWrite(3, 0, 8'h41);
    hostWrite(3, 1, 8'hAA);
    applyStimulus(8, 8'h01, 0, 3, 8'h41, 0, 0, 0);
    applyStimulus(8, 8'h42, 2, 3, 8'hAA, 1, 8'hBB, 0);
    applyStimulus(8, 8'h42, 2, 3, 8'hBB, 0, 0, 0);

    $display("[TB] reset during reply write");
    applyStimulus(1, 8'h42, 1, 0, 8'h5A, 0, 0, 1);
    arbOrder = '{0, 1, 2, 3, 0, 1, 2, 3};
    for (int i = 0; i < 8; i++)
      applyStimulus(15, 8'h42, 1, arbOrder[i], 8'h5A, 0, 0, 0);
    applyStimulus(1, 8'h00, 2, 0, -2, 0, 0, 0);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 250; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) begin
        hostWrite($urandom_range(0, 3), $urandom_range(0, 7), 8'($urandom));
      end else if (r == 1) begin
        int pick;
        pick = $urandom_range(0, 2);
        hostWrite($urandom_range(0, 3), 0,
                  (pick == 0) ? 8'h41 : (pick == 1) ? 8'h73 : 8'($urandom));
      end else if (r == 2) begin
        ppb_irq_flags = 4'h0;
        @(negedge clk);
        checkOutput("idleQuiet", 32'(ppb_read), 0);
      end else begin
        int         idx;
        logic [7:0] cmd;
        idx = ($urandom_range(0, 9) < 3) ? 0 : $urandom_range(1, 10);
        cmd = (idx == 0 && $urandom_range(0, 4) != 0) ? 8'h01 : 8'($urandom);
        applyStimulus($urandom_range(1, 15), cmd, idx, -1, -1,
                      ($urandom_range(0, 7) == 0), 8'($urandom), 0);
      end
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
